// File: rtl/capdelta_pkg.sv
// Shared definitions for capdelta: the two-state priming FSM encoding.
package capdelta_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/capdelta_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data is a registered copy of the
// head entry and keeps its last value once the FIFO runs empty.
module capdelta_fifo #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data,
  input  logic         wr_ena,
  output logic         full,
  output logic [W-1:0] rd_data,
  input  logic         rd_ena,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [W-1:0]            mem [DEPTH];
  logic [CW-1:0]           wr_ptr_reg, rd_ptr_reg, count_reg;
  logic [CW-1:0]           rd_ptr_next, count_next;
  logic [W-1:0]            head_reg;
  logic                    do_wr, do_rd, head_is_new;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_rd = rd_ena && !empty;
  assign do_wr = wr_ena && (!full || do_rd);

  assign rd_ptr_next = rd_ptr_reg + CW'(do_rd);
  assign count_next  = count_reg + CW'(do_wr) - CW'(do_rd);

  // The written word becomes the head when nothing older survives this cycle.
  assign head_is_new = (count_reg == '0) || (count_reg == CW'(1) && do_rd);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (do_wr && wr_ptr_reg[DEPTH_LOG2-1:0] == DEPTH_LOG2'(gi)) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + CW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) begin
        if (do_wr && head_is_new) begin
          head_reg <= wr_data;
        end else begin
          head_reg <= mem[rd_ptr_next[DEPTH_LOG2-1:0]];
        end
      end
    end
  end

  assign rd_data = head_reg;

endmodule

// File: rtl/capdelta.sv
// Capture-snapshot delta engine: samples cap_val one cycle after cap_stb and
// queues modular differences. Optional min/max stats with CAPDELTA_STATS_EN.
module capdelta
  import capdelta_pkg::*;
#(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cap_val,
  input  logic         cap_stb,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         primed,
  output logic         ovf,
  input  logic         ovf_clr
`ifdef CAPDELTA_STATS_EN
  ,
  output logic [W-1:0] dmin,
  output logic [W-1:0] dmax,
  input  logic         stats_clr
`endif
);

  state_t        state_reg, state_next;
  logic          smp_stb_reg;
  logic [W-1:0]  prev_reg;
  logic          ovf_reg;
  logic          load_prev, delta_vld;
  logic [W-1:0]  delta;
  logic          fifo_full, fifo_empty, pop, drop;

  // The counter latches cnt_cap on the strobe edge, so the value is valid a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_stb_reg <= 1'b0;
    end else begin
      smp_stb_reg <= cap_stb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PRIME;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_prev  = 1'b0;
    delta_vld  = 1'b0;
    case (state_reg)
      PRIME: begin
        if (smp_stb_reg) begin
          load_prev  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (smp_stb_reg) begin
          load_prev = 1'b1;
          delta_vld = 1'b1;
        end
      end
      default: state_next = PRIME;
    endcase
  end

  assign delta = cap_val - prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
    end else if (load_prev) begin
      prev_reg <= cap_val;
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = delta_vld && fifo_full && !pop;

  // Setting wins over clearing so a coincident drop is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  capdelta_fifo #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (delta),
    .wr_ena  (delta_vld),
    .full    (fifo_full),
    .rd_data (out_data),
    .rd_ena  (out_ready),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign primed    = (state_reg == RUN);
  assign ovf       = ovf_reg;

`ifdef CAPDELTA_STATS_EN
  logic [W-1:0] dmin_reg, dmax_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dmin_reg <= '1;
      dmax_reg <= '0;
    end else if (stats_clr) begin
      dmin_reg <= delta_vld ? delta : '1;
      dmax_reg <= delta_vld ? delta : '0;
    end else if (delta_vld) begin
      if (delta < dmin_reg) dmin_reg <= delta;
      if (delta > dmax_reg) dmax_reg <= delta;
    end
  end

  assign dmin = dmin_reg;
  assign dmax = dmax_reg;
`endif

endmodule

// File: tb/tb_capdelta.sv
// Self-checking bench for capdelta: directed tables, corner sequences and a
// randomized run against a queue-based reference model.
module tb_capdelta;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cap_val;
  logic         cap_stb;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         primed;
  logic         ovf;
  logic         ovf_clr;
`ifdef CAPDELTA_STATS_EN
  logic [W-1:0] dmin, dmax;
  logic         stats_clr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  capdelta #(.W(W), .DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_val   (cap_val),
    .cap_stb   (cap_stb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .primed    (primed),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef CAPDELTA_STATS_EN
    ,
    .dmin      (dmin),
    .dmax      (dmax),
    .stats_clr (stats_clr)
`endif
  );

  typedef struct {
    logic [W-1:0] val;
    logic [W-1:0] exp_delta;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Strobe cycle, then the sample cycle carrying the counter value.
  task automatic capture(input logic [W-1:0] v, input logic clr, input logic rdy);
    cap_stb = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    cap_stb = 1'b0; cap_val = v; out_ready = rdy; ovf_clr = clr;
    tick();
    out_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [W-1:0] exp);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cap_stb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
`ifdef CAPDELTA_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
  endtask

  vec_t         tbl [5];
  logic [W-1:0] base;
  logic [W-1:0] m_prev;
  logic         m_primed, m_ovf, pending;
  logic [W-1:0] mq [$];

  initial begin
    cap_val = '0;
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_primed", 32'(primed), 0);
    chk("rst_ovf", 32'(ovf), 0);
`ifdef CAPDELTA_STATS_EN
    chk("rst_dmin", 32'(dmin), 32'hFFFF);
    chk("rst_dmax", 32'(dmax), 0);
`endif

    capture(16'h1000, 1'b0, 1'b0);
    chk("prime_primed", 32'(primed), 1);
    chk("prime_valid", 32'(out_valid), 0);

    tbl[0] = '{16'h1234, 16'h0234};
    tbl[1] = '{16'hFFFE, 16'hEDCA};
    tbl[2] = '{16'h0003, 16'h0005};
    tbl[3] = '{16'h0003, 16'h0000};
    tbl[4] = '{16'h8003, 16'h8000};
    for (int i = 0; i < 5; i++) begin
      capture(tbl[i].val, 1'b0, 1'b0);
      pop_expect($sformatf("tbl%0d", i), tbl[i].exp_delta);
      chk($sformatf("tbl%0d_empty", i), 32'(out_valid), 0);
    end

    // Overflow: deltas 10..50 with no consumer.
    base = 16'h8003;
    for (int i = 1; i <= 5; i++) begin
      base = base + W'(10 * i);
      capture(base, 1'b0, 1'b0);
      chk($sformatf("ovf_after%0d", i), 32'(ovf), (i == 5) ? 1 : 0);
    end
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_drain%0d", i), W'(10 * i));
    chk("ovf_drained", 32'(out_valid), 0);
    chk("ovf_held", 32'(ovf), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    // Drop in the same cycle as ovf_clr.
    for (int i = 1; i <= 4; i++) begin
      base = base + W'(i);
      capture(base, 1'b0, 1'b0);
    end
    base = base + W'(5);
    capture(base, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(ovf), 1);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("sw_drain%0d", i), W'(i));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Full FIFO with a pop in the push cycle.
    for (int i = 1; i <= 4; i++) begin
      base = base + W'(i);
      capture(base, 1'b0, 1'b0);
    end
    base = base + W'(5);
    capture(base, 1'b0, 1'b1);
    chk("fullpop_ovf", 32'(ovf), 0);
    for (int i = 2; i <= 5; i++) pop_expect($sformatf("fp_drain%0d", i), W'(i));

    // Reset the cycle after a strobe with two entries queued.
    capture(base + W'(3), 1'b0, 1'b0);
    capture(base + W'(7), 1'b0, 1'b0);
    cap_stb = 1'b1; tick();
    cap_stb = 1'b0; cap_val = 16'h7777; rst = 1'b1; tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_primed", 32'(primed), 0);
    chk("mrst_data", 32'(out_data), 0);
    tick();
    chk("mrst_no_sample", 32'(primed), 0);
    capture(16'h4000, 1'b0, 1'b0);
    chk("mrst_reprime", 32'(primed), 1);
    chk("mrst_reprime_valid", 32'(out_valid), 0);
    capture(16'h4007, 1'b0, 1'b0);
    pop_expect("mrst_first", 16'h0007);

`ifdef CAPDELTA_STATS_EN
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    capture(16'h4007 + 16'd7, 1'b0, 1'b1);
    capture(16'h4007 + 16'd10, 1'b0, 1'b1);
    capture(16'h4007 + 16'd19, 1'b0, 1'b1);
    chk("stats_min", 32'(dmin), 3);
    chk("stats_max", 32'(dmax), 9);
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    chk("stats_clr_min", 32'(dmin), 32'hFFFF);
    chk("stats_clr_max", 32'(dmax), 0);
`endif

    // Randomized run against a queue model built from the delta rules.
    do_reset();
    m_prev = '0; m_primed = 1'b0; m_ovf = 1'b0; pending = 1'b0;
    mq.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic         stb, rdy, clr, popped, dropped;
      logic [W-1:0] v;
      stb = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      v   = W'($urandom);
      cap_stb = stb; out_ready = rdy; ovf_clr = clr; cap_val = v;

      popped  = rdy && (mq.size() > 0);
      dropped = 1'b0;
      if (popped) void'(mq.pop_front());
      if (pending) begin
        if (!m_primed) begin
          m_primed = 1'b1;
        end else if (mq.size() < 4) begin
          mq.push_back(v - m_prev);
        end else begin
          dropped = 1'b1;
        end
        m_prev = v;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      pending = stb;

      tick();
      checks++;
      if (out_valid !== (mq.size() > 0) || primed !== m_primed || ovf !== m_ovf ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        failures++;
        $display("FAIL rand cyc%0d: got valid=%0b data=0x%0h primed=%0b ovf=%0b expected valid=%0b data=0x%0h primed=%0b ovf=%0b",
                 cyc, out_valid, out_data, primed, ovf, (mq.size() > 0),
                 (mq.size() > 0) ? mq[0] : out_data, m_primed, m_ovf);
      end
    end
    cap_stb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
